// File: rtl/led_sched_pkg.sv
// Shared constants for the LED pattern scheduler: FSM encoding and default tick prescale.
package led_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int PRESCALE_DEF = 1024;

endpackage

// File: rtl/led_sched_table.sv
// Pattern/duration table: DEPTH entries, one synchronous write port, one combinational read port.
module led_sched_table
  import led_sched_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  parameter  int DUR_W = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wpat,
  input  logic [DUR_W-1:0] wdur,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rpat,
  output logic [DUR_W-1:0] rdur
);

  logic [DEPTH-1:0][WIDTH-1:0] pat_q;
  logic [DEPTH-1:0][DUR_W-1:0] dur_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        pat_q[g] <= '0;
        dur_q[g] <= '0;
      end else if (we && waddr == AW'(g)) begin
        pat_q[g] <= wpat;
        dur_q[g] <= wdur;
      end
    end
  end

  assign rpat = pat_q[raddr];
  assign rdur = dur_q[raddr];

endmodule

// File: rtl/led_pattern_scheduler.sv
// Steps the LED bank through a programmable (pattern, duration) table on a prescaled tick.
// Define LED_SCHED_LOOPCNT_EN to add the saturating loop_cnt output.
module led_pattern_scheduler
  import led_sched_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 4,
  parameter  int DUR_W    = 16,
  parameter  int PRESCALE = PRESCALE_DEF,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic [DUR_W-1:0] cfg_dur,
  input  logic [AW-1:0]    cfg_last,
  input  logic             loop_mode,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    cur_idx,
  output logic [WIDTH-1:0] LED
`ifdef LED_SCHED_LOOPCNT_EN
  ,
  output logic [15:0]      loop_cnt
`endif
);

  localparam int PW = $clog2(PRESCALE);

  logic [1:0]       state;
  logic [PW-1:0]    psc;
  logic [DUR_W-1:0] dcnt;
  logic [AW-1:0]    last_q;
  logic             loop_q;
  logic [WIDTH-1:0] rd_pat;
  logic [DUR_W-1:0] rd_dur;
  logic             tick;

  led_sched_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .DUR_W (DUR_W)
  ) u_table (
    .CLK   (CLK),
    .RST   (RST),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wpat  (cfg_pattern),
    .wdur  (cfg_dur),
    .raddr (cur_idx),
    .rpat  (rd_pat),
    .rdur  (rd_dur)
  );

  assign tick = (psc == PW'(PRESCALE - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      LED      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_idx  <= '0;
      psc      <= '0;
      dcnt     <= '0;
      last_q   <= '0;
      loop_q   <= 1'b0;
`ifdef LED_SCHED_LOOPCNT_EN
      loop_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      // stop outranks start, ticks and the DONE transition alike
      if (stop && state != ST_IDLE) begin
        state   <= ST_IDLE;
        LED     <= '0;
        busy    <= 1'b0;
        cur_idx <= '0;
        psc     <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !stop) begin
              state    <= ST_LOAD;
              cur_idx  <= '0;
              busy     <= 1'b1;
              last_q   <= cfg_last;
              loop_q   <= loop_mode;
`ifdef LED_SCHED_LOOPCNT_EN
              loop_cnt <= '0;
`endif
            end
          end
          ST_LOAD: begin
            LED   <= rd_pat;
            dcnt  <= (rd_dur == '0) ? DUR_W'(1) : rd_dur;
            psc   <= '0;
            state <= ST_RUN;
          end
          ST_RUN: begin
            if (!tick) begin
              psc <= psc + PW'(1);
            end else begin
              psc <= '0;
              if (dcnt > DUR_W'(1)) begin
                dcnt <= dcnt - DUR_W'(1);
              end else if (cur_idx < last_q) begin
                cur_idx <= cur_idx + AW'(1);
                state   <= ST_LOAD;
              end else if (loop_q) begin
                cur_idx <= '0;
                state   <= ST_LOAD;
`ifdef LED_SCHED_LOOPCNT_EN
                if (loop_cnt != 16'hFFFF) loop_cnt <= loop_cnt + 16'd1;
`endif
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Directed bench for led_pattern_scheduler with PRESCALE=4, DEPTH=4, WIDTH=8.
module tb_led_pattern_scheduler;
  localparam int WIDTH = 8, DEPTH = 4, DUR_W = 16, PRESCALE = 4, AW = 2;

  logic CLK = 1'b0, RST = 1'b0;
  logic cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [WIDTH-1:0] cfg_pattern = '0;
  logic [DUR_W-1:0] cfg_dur = '0;
  logic [AW-1:0] cfg_last = '0;
  logic loop_mode = 1'b0, start = 1'b0, stop = 1'b0;
  logic busy, done;
  logic [AW-1:0] cur_idx;
  logic [WIDTH-1:0] LED;
`ifdef LED_SCHED_LOOPCNT_EN
  logic [15:0] loop_cnt;
`endif

  int n_checks = 0, n_fail = 0;

  led_pattern_scheduler #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .DUR_W(DUR_W), .PRESCALE(PRESCALE)
  ) dut (
    .CLK(CLK), .RST(RST), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_pattern(cfg_pattern), .cfg_dur(cfg_dur), .cfg_last(cfg_last),
    .loop_mode(loop_mode), .start(start), .stop(stop),
    .busy(busy), .done(done), .cur_idx(cur_idx), .LED(LED)
`ifdef LED_SCHED_LOOPCNT_EN
    , .loop_cnt(loop_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task step();
    @(posedge CLK); #1;
  endtask

  task wr(input logic [AW-1:0] a, input logic [7:0] p, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_pattern = p; cfg_dur = d;
    step();
    cfg_we = 1'b0;
  endtask

  task kill();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task test_reset();
    step(); step();
    n_checks++; if (LED !== 8'h00) begin n_fail++; $display("FAIL reset_led got %h exp 00", LED); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (cur_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got %0d exp 0", cur_idx); end
    @(negedge CLK); RST = 1'b1;
    step();
  endtask

  task test_oneshot();
    logic [7:0] el; logic eb, ed; logic [1:0] ei; int ndone;
    wr(0, 8'h01, 2); wr(1, 8'h02, 1);
    cfg_last = 2'd1; loop_mode = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    ndone = 0;
    for (int i = 0; i <= 16; i++) begin
      el = (i == 0) ? 8'h00 : (i <= 9) ? 8'h01 : 8'h02;
      eb = (i <= 14); ed = (i == 14); ei = (i <= 8) ? 2'd0 : 2'd1;
      if (done === 1'b1) ndone++;
      n_checks++; if (LED !== el) begin n_fail++; $display("FAIL oneshot_led i=%0d got %h exp %h", i, LED, el); end
      n_checks++; if (busy !== eb) begin n_fail++; $display("FAIL oneshot_busy i=%0d got %b exp %b", i, busy, eb); end
      n_checks++; if (done !== ed) begin n_fail++; $display("FAIL oneshot_done i=%0d got %b exp %b", i, done, ed); end
      n_checks++; if (cur_idx !== ei) begin n_fail++; $display("FAIL oneshot_idx i=%0d got %0d exp %0d", i, cur_idx, ei); end
      if (i < 16) step();
    end
    n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL oneshot_done_count got %0d exp 1", ndone); end
    // stop while idle must leave the held pattern alone
    kill();
    n_checks++; if (LED !== 8'h02) begin n_fail++; $display("FAIL idle_stop_led got %h exp 02", LED); end
  endtask

  task test_loop();
    logic [7:0] el;
    cfg_last = 2'd1; loop_mode = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    loop_mode = 1'b0; cfg_last = 2'd0;
    for (int i = 0; i <= 40; i++) begin
      el = (((i - 1) % 14) < 9) ? 8'h01 : 8'h02;
      if (i > 0) begin
        n_checks++; if (LED !== el) begin n_fail++; $display("FAIL loop_led i=%0d got %h exp %h", i, LED, el); end
      end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL loop_busy i=%0d got %b exp 1", i, busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL loop_done i=%0d got %b exp 0", i, done); end
`ifdef LED_SCHED_LOOPCNT_EN
      if (i == 13) begin n_checks++; if (loop_cnt !== 16'd0) begin n_fail++; $display("FAIL loop_cnt13 got %0d exp 0", loop_cnt); end end
      if (i == 14) begin n_checks++; if (loop_cnt !== 16'd1) begin n_fail++; $display("FAIL loop_cnt14 got %0d exp 1", loop_cnt); end end
      if (i == 40) begin n_checks++; if (loop_cnt !== 16'd2) begin n_fail++; $display("FAIL loop_cnt40 got %0d exp 2", loop_cnt); end end
`endif
      if (i < 40) step();
    end
    kill();
    n_checks++; if (LED !== 8'h00) begin n_fail++; $display("FAIL loop_kill_led got %h exp 00", LED); end
  endtask

  task test_stop();
    cfg_last = 2'd1; loop_mode = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 13; i++) step();
    n_checks++; if (cur_idx !== 2'd1) begin n_fail++; $display("FAIL stop_pre_idx got %0d exp 1", cur_idx); end
    // this edge is entry 1's final tick, which would otherwise finish the sequence
    stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    n_checks++; if (LED !== 8'h00) begin n_fail++; $display("FAIL stop_led got %h exp 00", LED); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy got %b exp 0", busy); end
    n_checks++; if (cur_idx !== 2'd0) begin n_fail++; $display("FAIL stop_idx got %0d exp 0", cur_idx); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stop_done i=%0d got %b exp 0", i, done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_idle_busy i=%0d got %b exp 0", i, busy); end
      step();
    end
  endtask

  task test_dur0_live();
    logic [7:0] el;
    wr(0, 8'h11, 0); wr(1, 8'h22, 1);
    cfg_last = 2'd1; loop_mode = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      el = (i <= 5) ? 8'h11 : (i <= 10) ? 8'h22 : 8'hAA;
      if (i > 0) begin
        n_checks++; if (LED !== el) begin n_fail++; $display("FAIL dur0_led i=%0d got %h exp %h", i, LED, el); end
      end
      if (i == 2) begin cfg_we = 1'b1; cfg_addr = 2'd0; cfg_pattern = 8'hAA; cfg_dur = 16'd0; end
      if (i == 3) cfg_we = 1'b0;
      if (i < 12) step();
    end
    kill();
  endtask

  task test_back_to_back();
    logic [7:0] el; logic eb; logic [1:0] ei;
    wr(0, 8'h01, 2); wr(1, 8'h02, 1);
    cfg_last = 2'd1; loop_mode = 1'b0;
    start = 1'b1; step();
    for (int i = 0; i <= 17; i++) begin
      el = (i == 0) ? 8'h00 : (i <= 9) ? 8'h01 : (i <= 16) ? 8'h02 : 8'h01;
      eb = (i != 15);
      ei = (i <= 8 || i >= 16) ? 2'd0 : 2'd1;
      n_checks++; if (LED !== el) begin n_fail++; $display("FAIL b2b_led i=%0d got %h exp %h", i, LED, el); end
      n_checks++; if (busy !== eb) begin n_fail++; $display("FAIL b2b_busy i=%0d got %b exp %b", i, busy, eb); end
      n_checks++; if (cur_idx !== ei) begin n_fail++; $display("FAIL b2b_idx i=%0d got %0d exp %0d", i, cur_idx, ei); end
      n_checks++; if (done !== (i == 14)) begin n_fail++; $display("FAIL b2b_done i=%0d got %b exp %b", i, done, (i == 14)); end
      if (i < 17) step();
    end
    start = 1'b0;
    kill();
  endtask

  task test_async_reset();
    cfg_last = 2'd1; loop_mode = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_checks++; if (LED !== 8'h01) begin n_fail++; $display("FAIL areset_pre_led got %h exp 01", LED); end
    #3 RST = 1'b0;
    #1;
    n_checks++; if (LED !== 8'h00) begin n_fail++; $display("FAIL areset_led got %h exp 00", LED); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got %b exp 0", busy); end
    n_checks++; if (cur_idx !== 2'd0) begin n_fail++; $display("FAIL areset_idx got %0d exp 0", cur_idx); end
    #2 RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_post_busy i=%0d got %b exp 0", i, busy); end
      n_checks++; if (LED !== 8'h00) begin n_fail++; $display("FAIL areset_post_led i=%0d got %h exp 00", i, LED); end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_loop();
    test_stop();
    test_dur0_live();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
